mem_port_arbiter: RTL and testbench

- Shares the single 256-bit off-chip data-memory port between two cache-line requesters: port 0 is the data cache, port 1 is a future instruction cache.
- Round-robin arbitration with a level enable/ack handshake on both sides; one transaction is in flight at a time.
- Sits between the cache tops and the memory model, replacing the direct dcache-to-memory connection at CPU top level.

---
 rtl/mem_if_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the cache-to-memory port arbiter.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int LINE_W     = 256;
  localparam int MEM_ADDR_W = 32;

  localparam int DCACHE = 0;
  localparam int ICACHE = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-request round-robin picker: grants the port not granted last on a tie.
module rr_arb2
  import mem_if_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_update) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        // i_last is the index of the previous winner; ICACHE last means DCACHE now
        2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache-line memory port between the dcache (port 0) and icache (port 1),
// one transaction at a time, with a sticky timeout flag.
module mem_port_arbiter
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = LINE_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last;
  logic [1:0]        r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_write;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic [1:0]        w_win;
  logic              w_start;
  logic              w_busy;
  logic [CNT_W-1:0]  w_cnt_nxt;

  rr_arb2 u_rr_arb2 (
    .i_req    ({p1_enable_i, p0_enable_i}),
    .i_last   (r_last),
    .i_update (r_state == IDLE),
    .o_grant  (w_win)
  );

  assign w_start   = |w_win;
  assign w_busy    = (r_state == BUSY);
  assign w_cnt_nxt = (r_cnt == CNT_W'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = BUSY;
      BUSY:    if (mem_ack_i) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last  <= 1'b1;
      r_grant <= 2'b00;
      r_addr  <= '0;
      r_data  <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_grant <= w_win;
          r_last  <= w_win[ICACHE];
          r_addr  <= w_win[ICACHE] ? p1_addr_i  : p0_addr_i;
          r_data  <= w_win[ICACHE] ? p1_data_i  : p0_data_i;
          r_write <= w_win[ICACHE] ? p1_write_i : p0_write_i;
          // r_cnt holds the number of the current BUSY cycle, starting at 1
          r_cnt   <= CNT_W'(1);
        end
        BUSY: begin
          r_cnt <= w_cnt_nxt;
          if (!mem_ack_i && w_cnt_nxt == CNT_W'(TIMEOUT)) r_err <= 1'b1;
        end
        DONE:    r_grant <= 2'b00;
        default: ;
      endcase
    end
  end

  assign mem_enable_o = w_busy;
  assign mem_write_o  = w_busy & r_write;
  assign mem_addr_o   = r_addr;
  assign mem_data_o   = r_data;
  assign grant_o      = r_grant;
  assign err_o        = r_err;
  assign p0_ack_o     = w_busy & mem_ack_i & r_grant[DCACHE];
  assign p1_ack_o     = w_busy & mem_ack_i & r_grant[ICACHE];
  assign p0_data_o    = mem_data_i;
  assign p1_data_o    = mem_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenario bench for mem_port_arbiter (TIMEOUT=8).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [DW-1:0] p0_data_i, p1_data_i;
  logic [DW-1:0] p0_data_o, p1_data_o;
  logic          p0_ack_o, p1_ack_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic          mem_ack_i;
  logic [1:0]    grant_o;
  logic          err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .grant_o(grant_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
    p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({mem_enable_o, mem_write_o, p0_ack_o, p1_ack_o, err_o, grant_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {mem_enable_o, mem_write_o, p0_ack_o, p1_ack_o, err_o, grant_o});
    end
    n_checks++;
    if (mem_addr_o !== '0 || mem_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h data %h want 0", mem_addr_o, mem_data_o);
    end
    // ack outside BUSY must not be forwarded
    mem_ack_i = 1'b1; mem_data_i = {32{8'h3C}};
    #1;
    n_checks++;
    if ({p0_ack_o, p1_ack_o, mem_enable_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: got %b want 000", {p0_ack_o, p1_ack_o, mem_enable_o});
    end
    tick();
    mem_ack_i = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h0000_0400;
    n_checks++;
    if (mem_enable_o !== 1'b0) begin
      n_fail++; $display("FAIL sr_pre_enable: got %b want 0", mem_enable_o);
    end
    tick();
    n_checks++;
    if ({mem_enable_o, mem_write_o, grant_o} !== 4'b1001 || mem_addr_o !== 32'h400) begin
      n_fail++;
      $display("FAIL sr_grant: en/wr/gnt %b addr %h want 1001 400",
               {mem_enable_o, mem_write_o, grant_o}, mem_addr_o);
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      n_checks++;
      if (mem_enable_o !== 1'b1 || p0_ack_o !== 1'b0) begin
        n_fail++; $display("FAIL sr_wait%0d: en %b ack %b want 1 0", k, mem_enable_o, p0_ack_o);
      end
    end
    mem_ack_i = 1; mem_data_i = {32{8'hA5}};
    #1;
    n_checks++;
    if (p0_ack_o !== 1'b1 || p1_ack_o !== 1'b0 || p0_data_o !== {32{8'hA5}}) begin
      n_fail++;
      $display("FAIL sr_ack: ack0 %b ack1 %b data %h want 1 0 a5..", p0_ack_o, p1_ack_o, p0_data_o);
    end
    tick();
    mem_ack_i = 0; p0_enable_i = 0;
    n_checks++;
    if ({mem_enable_o, p0_ack_o, grant_o} !== 4'b0001) begin
      n_fail++; $display("FAIL sr_done: en/ack/gnt %b want 0001", {mem_enable_o, p0_ack_o, grant_o});
    end
    tick();
    n_checks++;
    if ({mem_enable_o, grant_o} !== 3'b000) begin
      n_fail++; $display("FAIL sr_idle: en/gnt %b want 000", {mem_enable_o, grant_o});
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    p0_enable_i = 1; p0_addr_i = 32'h100;
    p1_enable_i = 1; p1_addr_i = 32'h200;
    tick();
    n_checks++;
    if (grant_o !== 2'b01 || mem_addr_o !== 32'h100 || mem_enable_o !== 1'b1) begin
      n_fail++; $display("FAIL sim_first: gnt %b addr %h want 01 100", grant_o, mem_addr_o);
    end
    tick(); tick();
    mem_ack_i = 1; mem_data_i = {32{8'h11}};
    #1;
    n_checks++;
    if (p0_ack_o !== 1'b1 || p1_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL sim_ack0: ack0 %b ack1 %b want 1 0", p0_ack_o, p1_ack_o);
    end
    tick();
    mem_ack_i = 0; p0_enable_i = 0;
    n_checks++;
    if (mem_enable_o !== 1'b0 || p1_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL sim_gap1: en %b ack1 %b want 0 0", mem_enable_o, p1_ack_o);
    end
    tick();
    n_checks++;
    if (mem_enable_o !== 1'b0) begin
      n_fail++; $display("FAIL sim_gap2: en %b want 0", mem_enable_o);
    end
    tick();
    n_checks++;
    if (mem_enable_o !== 1'b1 || grant_o !== 2'b10 || mem_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL sim_second: en %b gnt %b addr %h want 1 10 200", mem_enable_o, grant_o, mem_addr_o);
    end
    mem_ack_i = 1; mem_data_i = {32{8'h22}};
    #1;
    n_checks++;
    if (p1_ack_o !== 1'b1 || p0_ack_o !== 1'b0 || p1_data_o !== {32{8'h22}}) begin
      n_fail++; $display("FAIL sim_ack1: ack1 %b ack0 %b data %h", p1_ack_o, p0_ack_o, p1_data_o);
    end
    tick();
    mem_ack_i = 0; p1_enable_i = 0;
    tick();
  endtask

  task automatic test_fair_alternation();
    logic [1:0] exp_g;
    apply_reset();
    p0_enable_i = 1; p0_addr_i = 32'hA0;
    p1_enable_i = 1; p1_addr_i = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      n_checks++;
      if (grant_o !== exp_g || mem_enable_o !== 1'b1) begin
        n_fail++; $display("FAIL fair_grant%0d: gnt %b en %b want %b 1", i, grant_o, mem_enable_o, exp_g);
      end
      mem_ack_i = 1;
      #1;
      n_checks++;
      if ({p1_ack_o, p0_ack_o} !== exp_g) begin
        n_fail++; $display("FAIL fair_ack%0d: acks %b want %b", i, {p1_ack_o, p0_ack_o}, exp_g);
      end
      tick();
      mem_ack_i = 0;
      tick();
    end
    p0_enable_i = 0; p1_enable_i = 0;
    tick();
  endtask

  task automatic test_input_stability();
    logic [DW-1:0] d1;
    d1 = {8{32'hDEAD_BEEF}};
    apply_reset();
    p0_enable_i = 1; p0_write_i = 1; p0_addr_i = 32'h300; p0_data_i = d1;
    tick();
    p0_addr_i = 32'hFFFF_FFF0; p0_data_i = {8{32'h1234_5678}}; p0_write_i = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) p0_enable_i = 0;
      n_checks++;
      if (mem_addr_o !== 32'h300 || mem_data_o !== d1 || mem_write_o !== 1'b1 || mem_enable_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stab%0d: addr %h wr %b en %b data_ok %b want 300 1 1 1", k,
                 mem_addr_o, mem_write_o, mem_enable_o, mem_data_o === d1);
      end
      tick();
    end
    mem_ack_i = 1;
    #1;
    n_checks++;
    if (p0_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL stab_ack_after_drop: ack0 %b want 1", p0_ack_o);
    end
    tick();
    mem_ack_i = 0;
    n_checks++;
    if ({mem_enable_o, mem_write_o} !== 2'b00) begin
      n_fail++; $display("FAIL stab_done: en/wr %b want 00", {mem_enable_o, mem_write_o});
    end
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h700;
    tick();
    for (int c = 1; c <= 7; c++) begin
      n_checks++;
      if (err_o !== 1'b0) begin
        n_fail++; $display("FAIL to_early_c%0d: err %b want 0", c, err_o);
      end
      tick();
    end
    n_checks++;
    if (err_o !== 1'b1 || mem_enable_o !== 1'b1) begin
      n_fail++; $display("FAIL to_c8: err %b en %b want 1 1", err_o, mem_enable_o);
    end
    tick(); tick(); tick();
    mem_ack_i = 1; mem_data_i = {32{8'h5A}};
    #1;
    n_checks++;
    if (p0_ack_o !== 1'b1 || err_o !== 1'b1 || p0_data_o !== {32{8'h5A}}) begin
      n_fail++; $display("FAIL to_late_ack: ack %b err %b want 1 1", p0_ack_o, err_o);
    end
    tick();
    mem_ack_i = 0; p0_enable_i = 0;
    tick(); tick();
    n_checks++;
    if (err_o !== 1'b1 || mem_enable_o !== 1'b0) begin
      n_fail++; $display("FAIL to_sticky: err %b en %b want 1 0", err_o, mem_enable_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h600; p1_data_i = {32{8'h77}};
    tick(); tick(); tick();
    rst_i = 1; p1_enable_i = 0;
    tick();
    rst_i = 0;
    n_checks++;
    if ({mem_enable_o, mem_write_o, p0_ack_o, p1_ack_o, err_o, grant_o} !== 7'b0 ||
        mem_addr_o !== '0 || mem_data_o !== '0) begin
      n_fail++;
      $display("FAIL rmb_reset: ctrl %b addr %h want 0",
               {mem_enable_o, mem_write_o, p0_ack_o, p1_ack_o, err_o, grant_o}, mem_addr_o);
    end
    mem_ack_i = 1;
    #1;
    n_checks++;
    if (p1_ack_o !== 1'b0 || p0_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL rmb_stale_ack: ack1 %b ack0 %b want 0 0", p1_ack_o, p0_ack_o);
    end
    tick();
    mem_ack_i = 0;
    p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h500;
    tick();
    n_checks++;
    if (mem_enable_o !== 1'b1 || grant_o !== 2'b10 || mem_addr_o !== 32'h500 || mem_write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rmb_next: en %b gnt %b addr %h wr %b want 1 10 500 0",
               mem_enable_o, grant_o, mem_addr_o, mem_write_o);
    end
    mem_ack_i = 1;
    #1;
    n_checks++;
    if (p1_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL rmb_next_ack: ack1 %b want 1", p1_ack_o);
    end
    tick();
    mem_ack_i = 0; p1_enable_i = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fair_alternation();
    test_input_stability();
    test_timeout();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
